tdm_demux_1bit: RTL



---
 rtl/comb_pkg.sv | 10 +
 rtl/tdm_slot_counter.sv | 34 +++
 rtl/tdm_demux_1bit.sv | 86 ++++++++
 3 files changed

// File: rtl/comb_pkg.sv
// rtl/comb_pkg.sv - shared state encoding for the tdm demux
package comb_pkg;

  // Frame FSM: IDLE waits for a sync marker, RUN collects slots 1..OUTS-1
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_slot_counter.sv
// rtl/tdm_slot_counter.sv - mod-OUTS slot index counter
module tdm_slot_counter #(
  parameter  int OUTS = 6,
  localparam int SW   = $clog2(OUTS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          load1,
  input  logic          inc,
  output logic [SW-1:0] cnt,
  output logic          at_last
);

  // SW-bit constants so non-power-of-two OUTS never walks through unused codes
  localparam logic [SW-1:0] LAST = SW'(OUTS - 1);
  localparam logic [SW-1:0] ONE  = SW'(1);

  assign at_last = (cnt == LAST);

  // Slot count: clear beats load-to-one beats increment; increment wraps at the last slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load1) begin
      cnt <= ONE;
    end else if (inc) begin
      cnt <= at_last ? '0 : cnt + ONE;
    end
  end

endmodule

// File: rtl/tdm_demux_1bit.sv
// rtl/tdm_demux_1bit.sv - serial TDM link to parallel frame demultiplexer
module tdm_demux_1bit
  import comb_pkg::*;
#(
  parameter  int OUTS = 6,
  localparam int SW   = $clog2(OUTS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            d,
  input  logic            sync,
  output logic [OUTS-1:0] q,
  output logic [SW-1:0]   slot,
  output logic            frame_done,
  output logic            resync_err,
  output logic            busy
);

  state_t          state;
  logic [OUTS-1:0] shd;
  logic            at_last;
  logic            cnt_clr;
  logic            cnt_load1;
  logic            cnt_inc;

  // A sync strobe always restarts at slot 1; a non-sync strobe in RUN advances or completes
  assign cnt_load1 = en & sync;
  assign cnt_clr   = en & ~sync & (state == ST_RUN) & at_last;
  assign cnt_inc   = en & ~sync & (state == ST_RUN) & ~at_last;

  tdm_slot_counter #(
    .OUTS (OUTS)
  ) u_slot_counter (
    .clk     (clk),
    .reset   (reset),
    .clr     (cnt_clr),
    .load1   (cnt_load1),
    .inc     (cnt_inc),
    .cnt     (slot),
    .at_last (at_last)
  );

  assign busy = (state == ST_RUN);

  // Frame FSM: fill the shadow word, publish it to q only on a clean last slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      shd        <= '0;
      q          <= '0;
      frame_done <= 1'b0;
      resync_err <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      resync_err <= 1'b0;
      if (en) begin
        case (state)
          ST_IDLE: begin
            // Bits before the first sync are dropped silently
            if (sync) begin
              shd   <= {{(OUTS-1){1'b0}}, d};
              state <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (sync) begin
              // Early sync (including on the last slot) abandons the partial frame
              resync_err <= 1'b1;
              shd        <= {{(OUTS-1){1'b0}}, d};
            end else if (at_last) begin
              q          <= {d, shd[OUTS-2:0]};
              frame_done <= 1'b1;
              state      <= ST_IDLE;
            end else begin
              for (int k = 0; k < OUTS; k++) begin
                if (slot == SW'(k)) shd[k] <= d;
              end
            end
          end
        endcase
      end
    end
  end

endmodule
